mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter with independent read and write FSMs.
// Define MEM_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_ar_valid,
    output logic                 m0_ar_ready,
    input  logic [ADDR_WDTH-1:0] m0_ar_addr,
    output logic                 m0_r_valid,
    input  logic                 m0_r_ready,
    output logic [DATA_WDTH-1:0] m0_r_data,
    output logic [RESP_WDTH-1:0] m0_r_resp,
    input  logic                 m0_aw_valid,
    output logic                 m0_aw_ready,
    input  logic [ADDR_WDTH-1:0] m0_aw_addr,
    input  logic                 m0_w_valid,
    output logic                 m0_w_ready,
    input  logic [DATA_WDTH-1:0] m0_w_data,
    output logic                 m0_b_valid,
    input  logic                 m0_b_ready,
    output logic [RESP_WDTH-1:0] m0_b_resp,
    input  logic                 m1_ar_valid,
    output logic                 m1_ar_ready,
    input  logic [ADDR_WDTH-1:0] m1_ar_addr,
    output logic                 m1_r_valid,
    input  logic                 m1_r_ready,
    output logic [DATA_WDTH-1:0] m1_r_data,
    output logic [RESP_WDTH-1:0] m1_r_resp,
    input  logic                 m1_aw_valid,
    output logic                 m1_aw_ready,
    input  logic [ADDR_WDTH-1:0] m1_aw_addr,
    input  logic                 m1_w_valid,
    output logic                 m1_w_ready,
    input  logic [DATA_WDTH-1:0] m1_w_data,
    output logic                 m1_b_valid,
    input  logic                 m1_b_ready,
    output logic [RESP_WDTH-1:0] m1_b_resp,
    output logic                 s_ar_valid,
    input  logic                 s_ar_ready,
    output logic [ADDR_WDTH-1:0] s_ar_addr,
    input  logic                 s_r_valid,
    output logic                 s_r_ready,
    input  logic [DATA_WDTH-1:0] s_r_data,
    input  logic [RESP_WDTH-1:0] s_r_resp,
    output logic                 s_aw_valid,
    input  logic                 s_aw_ready,
    output logic [ADDR_WDTH-1:0] s_aw_addr,
    output logic                 s_w_valid,
    input  logic                 s_w_ready,
    output logic [DATA_WDTH-1:0] s_w_data,
    input  logic                 s_b_valid,
    output logic                 s_b_ready,
    input  logic [RESP_WDTH-1:0] s_b_resp,
    output logic                 rd_busy,
    output logic                 wr_busy
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;

    rd_state_t r_rd_state;
    rd_state_t w_rd_state_nx;
    wr_state_t r_wr_state;
    wr_state_t w_wr_state_nx;

    logic r_rd_gnt;
    logic w_rd_gnt_nx;
    logic r_wr_gnt;
    logic w_wr_gnt_nx;
    logic r_aw_done;
    logic w_aw_done_nx;
    logic r_w_done;
    logic w_w_done_nx;

    logic w_rd_pick;
    logic w_wr_pick;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_rd_act;
    logic w_rd_addr;
    logic w_rd_data;
    logic w_wr_act;
    logic w_wr_xfer;
    logic w_wr_resp;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // m1 only wins when m0 is not asking
    assign w_rd_pick = ~m0_ar_valid;
    assign w_wr_pick = ~m0_aw_valid;
`else
    logic r_rd_last;
    logic r_wr_last;
    logic w_rd_done;
    logic w_wr_done;

    assign w_rd_pick = (m0_ar_valid & m1_ar_valid) ? ~r_rd_last
                                                   : m1_ar_valid;
    assign w_wr_pick = (m0_aw_valid & m1_aw_valid) ? ~r_wr_last
                                                   : m1_aw_valid;
    assign w_rd_done = (r_rd_state == R_DATA) & w_r_hs;
    assign w_wr_done = (r_wr_state == W_RESP) & w_b_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_last <= 1'b1;
            r_wr_last <= 1'b1;
        end else begin
            if (w_rd_done) r_rd_last <= r_rd_gnt;
            if (w_wr_done) r_wr_last <= r_wr_gnt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_rd_gnt   <= 1'b0;
            r_wr_state <= W_IDLE;
            r_wr_gnt   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nx;
            r_rd_gnt   <= w_rd_gnt_nx;
            r_wr_state <= w_wr_state_nx;
            r_wr_gnt   <= w_wr_gnt_nx;
            r_aw_done  <= w_aw_done_nx;
            r_w_done   <= w_w_done_nx;
        end
    end

    assign w_rd_act  = (r_rd_state != R_IDLE);
    assign w_rd_addr = (r_rd_state == R_ADDR);
    assign w_rd_data = (r_rd_state == R_DATA);
    assign w_wr_act  = (r_wr_state != W_IDLE);
    assign w_wr_xfer = (r_wr_state == W_XFER);
    assign w_wr_resp = (r_wr_state == W_RESP);

    assign w_ar_hs  = s_ar_valid & s_ar_ready;
    assign w_r_hs   = s_r_valid & s_r_ready;
    assign w_aw_hs  = s_aw_valid & s_aw_ready;
    assign w_w_hs   = s_w_valid & s_w_ready;
    assign w_b_hs   = s_b_valid & s_b_ready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    always_comb begin
        w_rd_state_nx = r_rd_state;
        w_rd_gnt_nx   = r_rd_gnt;
        unique case (r_rd_state)
            R_IDLE: begin
                if (m0_ar_valid | m1_ar_valid) begin
                    w_rd_state_nx = R_ADDR;
                    w_rd_gnt_nx   = w_rd_pick;
                end
            end
            R_ADDR: if (w_ar_hs) w_rd_state_nx = R_DATA;
            R_DATA: if (w_r_hs) w_rd_state_nx = R_IDLE;
            default: w_rd_state_nx = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_state_nx = r_wr_state;
        w_wr_gnt_nx   = r_wr_gnt;
        w_aw_done_nx  = 1'b0;
        w_w_done_nx   = 1'b0;
        unique case (r_wr_state)
            W_IDLE: begin
                if (m0_aw_valid | m1_aw_valid) begin
                    w_wr_state_nx = W_XFER;
                    w_wr_gnt_nx   = w_wr_pick;
                end
            end
            W_XFER: begin
                // AW and W may complete in either order or together
                if (w_aw_fin & w_w_fin) begin
                    w_wr_state_nx = W_RESP;
                end else begin
                    w_aw_done_nx = w_aw_fin;
                    w_w_done_nx  = w_w_fin;
                end
            end
            W_RESP: if (w_b_hs) w_wr_state_nx = W_IDLE;
            default: w_wr_state_nx = W_IDLE;
        endcase
    end

    assign s_ar_valid  = w_rd_addr
                       & (r_rd_gnt ? m1_ar_valid : m0_ar_valid);
    assign s_ar_addr   = w_rd_addr
                       ? (r_rd_gnt ? m1_ar_addr : m0_ar_addr) : '0;
    assign m0_ar_ready = w_rd_addr & ~r_rd_gnt & s_ar_ready;
    assign m1_ar_ready = w_rd_addr &  r_rd_gnt & s_ar_ready;
    assign s_r_ready   = w_rd_data
                       & (r_rd_gnt ? m1_r_ready : m0_r_ready);
    assign m0_r_valid  = w_rd_data & ~r_rd_gnt & s_r_valid;
    assign m1_r_valid  = w_rd_data &  r_rd_gnt & s_r_valid;
    assign m0_r_data   = (w_rd_act & ~r_rd_gnt) ? s_r_data : '0;
    assign m1_r_data   = (w_rd_act &  r_rd_gnt) ? s_r_data : '0;
    assign m0_r_resp   = (w_rd_act & ~r_rd_gnt) ? s_r_resp : '0;
    assign m1_r_resp   = (w_rd_act &  r_rd_gnt) ? s_r_resp : '0;
    assign rd_busy     = w_rd_act;

    assign s_aw_valid  = w_wr_xfer & ~r_aw_done
                       & (r_wr_gnt ? m1_aw_valid : m0_aw_valid);
    assign s_aw_addr   = w_wr_xfer
                       ? (r_wr_gnt ? m1_aw_addr : m0_aw_addr) : '0;
    assign m0_aw_ready = w_wr_xfer & ~r_aw_done & ~r_wr_gnt & s_aw_ready;
    assign m1_aw_ready = w_wr_xfer & ~r_aw_done &  r_wr_gnt & s_aw_ready;
    assign s_w_valid   = w_wr_xfer & ~r_w_done
                       & (r_wr_gnt ? m1_w_valid : m0_w_valid);
    assign s_w_data    = w_wr_xfer
                       ? (r_wr_gnt ? m1_w_data : m0_w_data) : '0;
    assign m0_w_ready  = w_wr_xfer & ~r_w_done & ~r_wr_gnt & s_w_ready;
    assign m1_w_ready  = w_wr_xfer & ~r_w_done &  r_wr_gnt & s_w_ready;
    assign s_b_ready   = w_wr_resp
                       & (r_wr_gnt ? m1_b_ready : m0_b_ready);
    assign m0_b_valid  = w_wr_resp & ~r_wr_gnt & s_b_valid;
    assign m1_b_valid  = w_wr_resp &  r_wr_gnt & s_b_valid;
    assign m0_b_resp   = (w_wr_act & ~r_wr_gnt) ? s_b_resp : '0;
    assign m1_b_resp   = (w_wr_act &  r_wr_gnt) ? s_b_resp : '0;
    assign wr_busy     = w_wr_act;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized reads checked against a grant-rule reference model.
module tb_mem_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int RW = 1;

    logic clk;
    logic rst_n;
    logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready;
    logic m0_aw_valid, m0_aw_ready, m0_w_valid, m0_w_ready;
    logic m0_b_valid, m0_b_ready;
    logic [AW-1:0] m0_ar_addr, m0_aw_addr;
    logic [DW-1:0] m0_r_data, m0_w_data;
    logic [RW-1:0] m0_r_resp, m0_b_resp;
    logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready;
    logic m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_ready;
    logic m1_b_valid, m1_b_ready;
    logic [AW-1:0] m1_ar_addr, m1_aw_addr;
    logic [DW-1:0] m1_r_data, m1_w_data;
    logic [RW-1:0] m1_r_resp, m1_b_resp;
    logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
    logic s_b_valid, s_b_ready;
    logic [AW-1:0] s_ar_addr, s_aw_addr;
    logic [DW-1:0] s_r_data, s_w_data;
    logic [RW-1:0] s_r_resp, s_b_resp;
    logic rd_busy, wr_busy;

    int n_run;
    int n_fail;
    bit mdl_rd_last;
    bit mdl_wr_last;

    mem_port_arbiter #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
        .m0_ar_addr(m0_ar_addr),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
        .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp),
        .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready),
        .m0_aw_addr(m0_aw_addr),
        .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
        .m0_w_data(m0_w_data),
        .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
        .m0_b_resp(m0_b_resp),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
        .m1_ar_addr(m1_ar_addr),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
        .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp),
        .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready),
        .m1_aw_addr(m1_aw_addr),
        .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
        .m1_w_data(m1_w_data),
        .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
        .m1_b_resp(m1_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_ar_addr(s_ar_addr),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_aw_addr(s_aw_addr),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_w_data(s_w_data),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_b_resp(s_b_resp),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Arbitration rule: a lone requester wins; on a tie m0 wins under
    // fixed priority, otherwise the one not granted last.
    function automatic bit pick(bit v0, bit v1, bit last);
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (v0) return 1'b0;
        return 1'b1;
`else
        if (v0 && v1) return ~last;
        return v1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_ar_valid = 0; m0_ar_addr = '0; m0_r_ready = 0;
        m0_aw_valid = 0; m0_aw_addr = '0; m0_w_valid = 0;
        m0_w_data = '0; m0_b_ready = 0;
        m1_ar_valid = 0; m1_ar_addr = '0; m1_r_ready = 0;
        m1_aw_valid = 0; m1_aw_addr = '0; m1_w_valid = 0;
        m1_w_data = '0; m1_b_ready = 0;
        s_ar_ready = 0; s_r_valid = 0; s_r_data = '0; s_r_resp = '0;
        s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0; s_b_resp = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
        mdl_rd_last = 1'b1;
        mdl_wr_last = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        m0_ar_valid = 1; m0_ar_addr = 4'h5; m0_r_ready = 1;
        m1_aw_valid = 1; m1_w_valid = 1; m1_w_data = 32'h1111;
        m1_b_ready = 1; s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1;
        s_r_valid = 1; s_r_data = 32'hDEADBEEF; s_r_resp = 1;
        s_b_valid = 1; s_b_resp = 1;
        step();
        n_run++;
        if ({s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}
            !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_s_side: got %b want 00000",
                {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready});
        end
        n_run++;
        if ({m0_ar_ready, m1_ar_ready, m0_aw_ready, m1_aw_ready,
             m0_w_ready, m1_w_ready, m0_r_valid, m1_r_valid,
             m0_b_valid, m1_b_valid} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_m_side: nonzero handshake output");
        end
        n_run++;
        if ({rd_busy, wr_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_busy: got %b want 00", {rd_busy, wr_busy});
        end
        n_run++;
        if ({m0_r_data, m1_b_resp, s_ar_addr, s_w_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_data: r_data %h b_resp %h ar %h w %h",
                m0_r_data, m1_b_resp, s_ar_addr, s_w_data);
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
        mdl_rd_last = 1'b1;
        mdl_wr_last = 1'b1;
        step();
        n_run++;
        if ({rd_busy, wr_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_idle: got %b want 00", {rd_busy, wr_busy});
        end
    endtask

    task automatic test_single_read();
        m0_ar_valid = 1; m0_ar_addr = 4'd3;
        #1;
        n_run++;
        if (s_ar_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sr_idle_valid: got %b want 0", s_ar_valid);
        end
        step();
        n_run++;
        if ({s_ar_valid, s_ar_addr, m1_ar_ready, rd_busy}
            !== {1'b1, 4'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sr_addr: v %b a %0d m1rdy %b busy %b",
                s_ar_valid, s_ar_addr, m1_ar_ready, rd_busy);
        end
        s_ar_ready = 1;
        #1;
        n_run++;
        if ({m0_ar_ready, m1_ar_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL sr_ar_ready: got %b want 10",
                {m0_ar_ready, m1_ar_ready});
        end
        step();
        m0_ar_valid = 0; s_ar_ready = 0;
        s_r_valid = 1; s_r_data = 32'hA5; s_r_resp = 0; m0_r_ready = 1;
        #1;
        n_run++;
        if ({m0_r_valid, m1_r_valid, s_r_ready} !== 3'b101 ||
            m0_r_data !== 32'hA5 || m0_r_resp !== 1'b0 ||
            m1_r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL sr_rdata: v %b%b d %h resp %b m1d %h",
                m0_r_valid, m1_r_valid, m0_r_data, m0_r_resp, m1_r_data);
        end
        step();
        s_r_valid = 0; m0_r_ready = 0;
        mdl_rd_last = 1'b0;
        n_run++;
        if (rd_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sr_busy_fall: got %b want 0", rd_busy);
        end
    endtask

    task automatic test_round_robin();
        bit rg [4];
        bit wg [4];
        bit er;
        bit ew;
        int nr;
        int nw;
        apply_reset();
        nr = 0;
        nw = 0;
        m0_ar_valid = 1; m1_ar_valid = 1;
        m0_ar_addr = 4'd1; m1_ar_addr = 4'd2;
        m0_aw_valid = 1; m1_aw_valid = 1; m0_w_valid = 1; m1_w_valid = 1;
        m0_r_ready = 1; m1_r_ready = 1; m0_b_ready = 1; m1_b_ready = 1;
        s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1;
        s_r_valid = 1; s_b_valid = 1;
        for (int c = 0; c < 40 && (nr < 4 || nw < 4); c++) begin
            step();
            if ((m0_ar_ready || m1_ar_ready) && nr < 4) begin
                rg[nr] = m1_ar_ready;
                nr++;
            end
            if ((m0_aw_ready || m1_aw_ready) && nw < 4) begin
                wg[nw] = m1_aw_ready;
                nw++;
            end
        end
        n_run++;
        if (nr != 4 || nw != 4) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d/%0d grants want 4/4", nr, nw);
        end
        for (int i = 0; i < 4; i++) begin
            er = pick(1'b1, 1'b1, mdl_rd_last);
            ew = pick(1'b1, 1'b1, mdl_wr_last);
            mdl_rd_last = er;
            mdl_wr_last = ew;
            n_run++;
            if (rg[i] !== er || wg[i] !== ew) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: rd m%0d wr m%0d want m%0d m%0d",
                    i, rg[i], wg[i], er, ew);
            end
        end
        apply_reset();
    endtask

    task automatic test_write_w_first();
        m1_aw_valid = 1; m1_aw_addr = 4'd7;
        m1_w_valid = 1; m1_w_data = 32'h1234; m1_b_ready = 1;
        s_w_ready = 1;
        step();
        n_run++;
        if ({s_aw_valid, s_w_valid, m1_w_ready, m0_aw_ready, wr_busy}
            !== 5'b11101 || s_w_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL ww_xfer: flags %b data %h",
                {s_aw_valid, s_w_valid, m1_w_ready, m0_aw_ready, wr_busy},
                s_w_data);
        end
        step();
        n_run++;
        if ({s_w_valid, m1_w_ready, s_aw_valid, s_b_ready} !== 4'b0010) begin
            n_fail++;
            $display("FAIL ww_w_drop: got %b want 0010",
                {s_w_valid, m1_w_ready, s_aw_valid, s_b_ready});
        end
        step();
        n_run++;
        if ({s_b_ready, wr_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL ww_wait_aw: got %b want 01", {s_b_ready, wr_busy});
        end
        s_aw_ready = 1;
        #1;
        n_run++;
        if (m1_aw_ready !== 1'b1 || s_aw_addr !== 4'd7) begin
            n_fail++;
            $display("FAIL ww_aw: rdy %b addr %0d want 1 7",
                m1_aw_ready, s_aw_addr);
        end
        step();
        s_aw_ready = 0; m1_aw_valid = 0; m1_w_valid = 0;
        s_b_valid = 1; s_b_resp = 1;
        #1;
        n_run++;
        if ({s_b_ready, s_aw_valid, m1_b_valid, m0_b_valid} !== 4'b1010 ||
            m1_b_resp !== 1'b1 || m0_b_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL ww_resp: flags %b m1resp %b m0resp %b",
                {s_b_ready, s_aw_valid, m1_b_valid, m0_b_valid},
                m1_b_resp, m0_b_resp);
        end
        step();
        s_b_valid = 0; s_b_resp = 0; m1_b_ready = 0; s_w_ready = 0;
        mdl_wr_last = 1'b1;
        n_run++;
        if (wr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ww_busy_fall: got %b want 0", wr_busy);
        end
    endtask

    task automatic test_concurrent();
        m0_ar_valid = 1; m0_ar_addr = 4'd4;
        m1_aw_valid = 1; m1_aw_addr = 4'd6;
        m1_w_valid = 1; m1_w_data = 32'h55;
        step();
        n_run++;
        if ({s_ar_valid, s_aw_valid, s_w_valid, rd_busy, wr_busy}
            !== 5'b11111 || s_aw_addr !== 4'd6 || s_ar_addr !== 4'd4) begin
            n_fail++;
            $display("FAIL cc_both: flags %b ar %0d aw %0d",
                {s_ar_valid, s_aw_valid, s_w_valid, rd_busy, wr_busy},
                s_ar_addr, s_aw_addr);
        end
        s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1;
        step();
        clear_inputs();
        s_r_valid = 1; s_r_data = 32'hC3; s_b_valid = 1;
        m0_r_ready = 1; m1_b_ready = 1;
        #1;
        n_run++;
        if ({m0_r_valid, m1_b_valid} !== 2'b11 || m0_r_data !== 32'hC3) begin
            n_fail++;
            $display("FAIL cc_resp: v %b%b data %h",
                m0_r_valid, m1_b_valid, m0_r_data);
        end
        step();
        clear_inputs();
        mdl_rd_last = 1'b0;
        mdl_wr_last = 1'b1;
        n_run++;
        if ({rd_busy, wr_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL cc_idle: got %b want 00", {rd_busy, wr_busy});
        end
    endtask

    task automatic test_reset_mid();
        m0_ar_valid = 1; m0_ar_addr = 4'd2; s_ar_ready = 1;
        step();
        step();
        m0_ar_valid = 0; s_ar_ready = 0;
        s_r_valid = 1; s_r_data = 32'h77; m0_r_ready = 0;
        #1;
        n_run++;
        if ({m0_r_valid, rd_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL rm_pending: got %b want 11", {m0_r_valid, rd_busy});
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({m0_r_valid, s_r_ready, rd_busy, s_ar_valid, m0_ar_ready}
            !== 5'b0 || m0_r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_async: flags %b data %h",
                {m0_r_valid, s_r_ready, rd_busy, s_ar_valid, m0_ar_ready},
                m0_r_data);
        end
        step();
        s_r_valid = 0; s_r_data = '0;
        rst_n = 1'b1;
        mdl_rd_last = 1'b1;
        mdl_wr_last = 1'b1;
        m1_ar_valid = 1; m1_ar_addr = 4'd9; s_ar_ready = 1;
        step();
        n_run++;
        if ({s_ar_valid, m1_ar_ready, m0_ar_ready} !== 3'b110 ||
            s_ar_addr !== 4'd9) begin
            n_fail++;
            $display("FAIL rm_regrant: flags %b addr %0d want 110 9",
                {s_ar_valid, m1_ar_ready, m0_ar_ready}, s_ar_addr);
        end
        step();
        m1_ar_valid = 0; s_ar_ready = 0;
        s_r_valid = 1; s_r_data = 32'hBEEF; m1_r_ready = 1;
        #1;
        n_run++;
        if (m1_r_valid !== 1'b1 || m1_r_data !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL rm_rdata: v %b data %h want 1 beef",
                m1_r_valid, m1_r_data);
        end
        step();
        clear_inputs();
        mdl_rd_last = 1'b1;
    endtask

    task automatic test_random_reads();
        bit p0, p1, w;
        logic [AW-1:0] a0, a1, ea;
        logic [DW-1:0] d;
        logic [RW-1:0] rs;
        p0 = 0;
        p1 = 0;
        a0 = '0;
        a1 = '0;
        m0_r_ready = 1;
        m1_r_ready = 1;
        for (int t = 0; t < 24; t++) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin
                p0 = 1; a0 = AW'($urandom);
            end
            if (!p1 && $urandom_range(1, 0) == 1) begin
                p1 = 1; a1 = AW'($urandom);
            end
            if (!p0 && !p1) begin
                p0 = 1; a0 = AW'($urandom);
            end
            m0_ar_valid = p0; m0_ar_addr = a0;
            m1_ar_valid = p1; m1_ar_addr = a1;
            w = pick(p0, p1, mdl_rd_last);
            ea = w ? a1 : a0;
            #1;
            n_run++;
            if (s_ar_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_idle[%0d]: s_ar_valid %b want 0",
                    t, s_ar_valid);
            end
            step();
            n_run++;
            if ({s_ar_valid, s_ar_addr} !== {1'b1, ea}) begin
                n_fail++;
                $display("FAIL rnd_addr[%0d]: v %b addr %0d want 1 %0d",
                    t, s_ar_valid, s_ar_addr, ea);
            end
            repeat ($urandom_range(2, 0)) step();
            s_ar_ready = 1;
            #1;
            n_run++;
            if ({m0_ar_ready, m1_ar_ready} !== (w ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d]: got %b want m%0d",
                    t, {m0_ar_ready, m1_ar_ready}, w);
            end
            step();
            s_ar_ready = 0;
            if (w) begin
                p1 = 0; m1_ar_valid = 0;
            end else begin
                p0 = 0; m0_ar_valid = 0;
            end
            repeat ($urandom_range(2, 0)) step();
            d = $urandom;
            rs = RW'($urandom);
            s_r_valid = 1; s_r_data = d; s_r_resp = rs;
            #1;
            n_run++;
            if ({m0_r_valid, m1_r_valid} !== (w ? 2'b01 : 2'b10) ||
                (w ? m1_r_data : m0_r_data) !== d ||
                (w ? m1_r_resp : m0_r_resp) !== rs ||
                (w ? m0_r_data : m1_r_data) !== '0) begin
                n_fail++;
                $display("FAIL rnd_rdata[%0d]: v %b%b d0 %h d1 %h want m%0d %h",
                    t, m0_r_valid, m1_r_valid, m0_r_data, m1_r_data, w, d);
            end
            step();
            s_r_valid = 0;
            mdl_rd_last = w;
            n_run++;
            if (rd_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_busy[%0d]: got %b want 0", t, rd_busy);
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_w_first();
        test_concurrent();
        test_reset_mid();
        test_random_reads();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
